// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and types for the Mini-MIPS datapath
package mips_pkg;

  localparam int          INSTR_W   = 32;
  localparam logic [5:0]  OPC_HALT  = 6'b111111;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_t;

  // Primary opcode field of a MIPS instruction word.
  function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/if_id_register.sv
// rtl/if_id_register.sv - IF/ID pipeline register with load, hold and bubble controls
module if_id_register
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               bubble,
  input  logic [INSTR_W-1:0] next_instr,
  input  logic [31:0]        next_pc4,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        pc4,
  output logic               valid
);

  // Bubble wins over load so a squashed fetch can never leak into decode;
  // with neither control asserted the register holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr <= NOP_INSTR;
      pc4   <= 32'h0;
      valid <= 1'b0;
    end else if (bubble) begin
      instr <= NOP_INSTR;
      pc4   <= 32'h0;
      valid <= 1'b0;
    end else if (load) begin
      instr <= next_instr;
      pc4   <= next_pc4;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC, fetch state machine and IF/ID feed for Mini-MIPS
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = OPC_HALT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [31:0]        ifid_pc4,
  output logic               ifid_valid,
  output logic               halted,
  output logic [31:0]        fetch_count
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic         halt_word;
  logic         ifid_load;
  logic         ifid_bubble;
  logic         unused_redirect_bits;

  assign imem_addr            = pc;
  assign pc_plus4             = pc + PC_STEP;
  assign halt_word            = (opcode_of(imem_instr) == HALT_OPCODE);
  assign unused_redirect_bits = ^redirect_pc[1:0];

  // IF/ID control: redirect squashes everything (including a halt word on the
  // wrong path), stall freezes, a halt word or the halted state inserts a bubble.
  always_comb begin
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    if (state == ST_HALTED) begin
      ifid_bubble = 1'b1;
    end else if (redirect_valid) begin
      ifid_bubble = 1'b1;
    end else if (!stall) begin
      if (halt_word) begin
        ifid_bubble = 1'b1;
      end else begin
        ifid_load = 1'b1;
      end
    end
  end

  // Fetch state machine owning PC, sticky halt flag and delivered-instruction count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      pc          <= {RESET_PC[31:2], 2'b00};
      halted      <= 1'b0;
      fetch_count <= 32'h0;
    end else begin
      case (state)
        ST_RUN: begin
          if (redirect_valid) begin
            pc <= {redirect_pc[31:2], 2'b00};
          end else if (stall) begin
            pc <= pc;
          end else if (halt_word) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
          end else begin
            pc          <= pc_plus4;
            fetch_count <= fetch_count + 32'd1;
          end
        end
        ST_HALTED: begin
          halted <= 1'b1;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  if_id_register u_if_id (
    .clk        (clk),
    .reset      (reset),
    .load       (ifid_load),
    .bubble     (ifid_bubble),
    .next_instr (imem_instr),
    .next_pc4   (pc_plus4),
    .instr      (ifid_instr),
    .pc4        (ifid_pc4),
    .valid      (ifid_valid)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        halted;
    logic [31:0] count;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        halted;
  logic [31:0] fetch_count;

  logic        reset2 = 1'b1;
  logic [31:0] w_addr;
  logic [31:0] w_instr;
  logic [31:0] w_pc4;
  logic        w_valid;
  logic        w_halted;
  logic [31:0] w_count;

  logic [31:0] mem [0:63];

  int total = 0;
  int bad   = 0;

  exp_t sb_q[$];

  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  logic        m_valid, m_halted;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[7:2]];

  instruction_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .ifid_instr     (ifid_instr),
    .ifid_pc4       (ifid_pc4),
    .ifid_valid     (ifid_valid),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk            (clk),
    .reset          (reset2),
    .stall          (1'b0),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .imem_addr      (w_addr),
    .imem_instr     (32'h2000_0001),
    .ifid_instr     (w_instr),
    .ifid_pc4       (w_pc4),
    .ifid_valid     (w_valid),
    .halted         (w_halted),
    .fetch_count    (w_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Drive one cycle, predict the outcome from the reference model, then compare.
  task automatic step(input logic rst, input logic stl, input logic rv, input logic [31:0] rpc);
    logic [31:0] fetched;
    exp_t e;
    exp_t o;
    reset = rst; stall = stl; redirect_valid = rv; redirect_pc = rpc;
    fetched = mem[m_pc[7:2]];
    if (rst) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_halted = 1'b0; m_count = 32'h0;
    end else if (m_halted) begin
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else if (rv) begin
      m_pc = {rpc[31:2], 2'b00};
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else if (stl) begin
      // everything holds
    end else if (fetched[31:26] == 6'b111111) begin
      m_halted = 1'b1;
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else begin
      m_instr = fetched; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      m_pc = m_pc + 32'd4; m_count = m_count + 32'd1;
    end
    e.addr = m_pc; e.instr = m_instr; e.pc4 = m_pc4;
    e.valid = m_valid; e.halted = m_halted; e.count = m_count;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    o = sb_q.pop_front();
    check("sb_addr",   imem_addr,            o.addr);
    check("sb_instr",  ifid_instr,           o.instr);
    check("sb_pc4",    ifid_pc4,             o.pc4);
    check("sb_valid",  {31'h0, ifid_valid},  {31'h0, o.valid});
    check("sb_halted", {31'h0, halted},      {31'h0, o.halted});
    check("sb_count",  fetch_count,          o.count);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0000;
    mem[0] = 32'h2231_0009;
    mem[1] = 32'h2008_0000;
    mem[2] = 32'h0109_5020;
    mem[3] = 32'h8D0B_0004;
    mem[4] = 32'hFC00_0000;
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_count = 0; m_valid = 0; m_halted = 0;

    // reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_valid", {31'h0, ifid_valid}, 32'h0);
    check("rst_count", fetch_count, 32'h0);

    // straight-line fetch
    step(0, 0, 0, 0);
    check("fetch0_instr", ifid_instr, 32'h2231_0009);
    check("fetch0_pc4",   ifid_pc4,   32'd4);
    step(0, 0, 0, 0);
    check("fetch1_instr", ifid_instr, 32'h2008_0000);
    check("fetch1_pc4",   ifid_pc4,   32'd8);
    check("fetch1_count", fetch_count, 32'd2);

    // stall for three cycles at PC=8
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      check("stall_addr",  imem_addr,   32'd8);
      check("stall_instr", ifid_instr,  32'h2008_0000);
      check("stall_count", fetch_count, 32'd2);
    end
    step(0, 0, 0, 0);
    check("resume_addr", imem_addr, 32'd12);
    check("resume_pc4",  ifid_pc4,  32'd12);

    // redirect while stalled, unaligned target
    step(0, 1, 1, 32'h0000_0009);
    check("redir_addr",  imem_addr, 32'd8);
    check("redir_instr", ifid_instr, 32'h0);
    check("redir_valid", {31'h0, ifid_valid}, 32'h0);
    step(0, 0, 0, 0);
    check("redir_tgt_instr", ifid_instr, 32'h0109_5020);
    check("redir_tgt_valid", {31'h0, ifid_valid}, 32'h1);

    // run into the halt word at 16
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("halt_flag",  {31'h0, halted}, 32'h1);
    check("halt_addr",  imem_addr, 32'd16);
    check("halt_count", fetch_count, 32'd5);
    step(0, 0, 1, 32'h0);
    check("halt_redir_ignored", imem_addr, 32'd16);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check("halt_valid", {31'h0, ifid_valid}, 32'h0);
    step(1, 0, 0, 0);
    check("halt_rst_addr", imem_addr, 32'h0);
    check("halt_rst_flag", {31'h0, halted}, 32'h0);

    // halt squashed by a same-cycle redirect
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    check("squash_pre_addr", imem_addr, 32'd16);
    step(0, 0, 1, 32'h0);
    check("squash_halted", {31'h0, halted}, 32'h0);
    check("squash_addr",   imem_addr, 32'h0);
    step(0, 0, 0, 0);

    // reset while stalled and redirecting
    step(0, 1, 0, 0);
    step(1, 1, 1, 32'h40);
    check("midrst_addr",  imem_addr, 32'h0);
    check("midrst_count", fetch_count, 32'h0);

    // PC wrap from 0xFFFFFFFC
    @(negedge clk);
    check("wrap_rst_addr", w_addr, 32'hFFFF_FFFC);
    reset2 = 1'b0;
    @(posedge clk);
    #1;
    check("wrap_pc4",   w_pc4,   32'h0);
    check("wrap_addr",  w_addr,  32'h0);
    check("wrap_instr", w_instr, 32'h2000_0001);
    check("wrap_valid", {31'h0, w_valid}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
